// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT frame capture path.
package fft_pkg;
    localparam int DW_DEFAULT = 32;
    localparam int MAX_LAYER  = 10;

    typedef struct packed {
        logic [DW_DEFAULT-1:0] re;
        logic [DW_DEFAULT-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    // Reverse the low `width` bits of value; upper bits come back zero.
    function automatic logic [MAX_LAYER-1:0] bitrev(input logic [MAX_LAYER-1:0] value,
                                                    input int width);
        logic [MAX_LAYER-1:0] r;
        logic [MAX_LAYER-1:0] v;
        r = '0;
        v = value;
        for (int i = 0; i < MAX_LAYER; i++) begin
            if (i < width) begin
                r = {r[MAX_LAYER-2:0], v[0]};
                v = v >> 1;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/fft_frame_capture_if.sv
// Input sample stream plus valid/ready replay stream of the frame capture block.
interface fft_frame_capture_if #(
    parameter int DW    = 32,
    parameter int LAYER = 5
);
    logic            start;
    logic            over;
    logic [DW-1:0]   data_in_real;
    logic [DW-1:0]   data_in_img;
    logic [DW-1:0]   data_out_real;
    logic [DW-1:0]   data_out_img;
    logic [LAYER-1:0] out_index;
    logic            out_valid;
    logic            out_last;
    logic            out_ready;
    logic            busy;
    logic            frame_err;

    modport master (
        output start, over, data_in_real, data_in_img, out_ready,
        input  data_out_real, data_out_img, out_index, out_valid, out_last, busy, frame_err
    );

    modport slave (
        input  start, over, data_in_real, data_in_img, out_ready,
        output data_out_real, data_out_img, out_index, out_valid, out_last, busy, frame_err
    );
endinterface

// File: rtl/fft_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port, no reset.
module fft_frame_ram #(
    parameter int AW = 5,
    parameter int W  = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [1<<AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fft_frame_capture.sv
// Captures one bit-reversed FFT frame and replays it in natural order on valid/ready.
module fft_frame_capture
    import fft_pkg::*;
#(
    parameter int LAYER  = 5,
    parameter int DW     = DW_DEFAULT,
    parameter int BITREV = 1
) (
    input logic clk,
    input logic rst,
    fft_frame_capture_if.slave bus
);
    localparam int N = 1 << LAYER;

    state_t           state, state_n;
    logic [LAYER-1:0] cnt, cnt_n, cnt_br, waddr;
    logic [LAYER:0]   rd_cnt;
    logic             err_n, we, re, hs;
    logic [2*DW-1:0]  rdata, skid, dout;
    logic             skid_vld, out_valid, out_last, frame_err;
    logic [LAYER-1:0] out_index;

    assign hs     = out_valid && bus.out_ready;
    assign cnt_br = LAYER'(bitrev(MAX_LAYER'(cnt), LAYER));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n   = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                state_n = CAPTURE;
                cnt_n   = LAYER'(1);
            end
            CAPTURE: begin
                if (bus.start) begin
                    // restart: the new start sample becomes sample 0
                    err_n = 1'b1;
                    cnt_n = LAYER'(1);
                end else if (bus.over && cnt == LAYER'(N-1)) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else if (bus.over || cnt == LAYER'(N-1)) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + LAYER'(1);
                end
            end
            DRAIN: begin
                err_n = bus.start;
                if (hs && out_last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        we    = (state == CAPTURE) || (state == IDLE && bus.start);
        waddr = bus.start ? '0 : ((BITREV != 0) ? cnt_br : cnt);
        // next read issues alongside the handshake of the current word
        re    = (state == DRAIN) && (rd_cnt < (LAYER+1)'(N)) && (!out_valid || bus.out_ready);
    end

    fft_frame_ram #(.AW(LAYER), .W(2*DW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata ({bus.data_in_real, bus.data_in_img}),
        .re    (re),
        .raddr (rd_cnt[LAYER-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= '0;
            frame_err <= 1'b0;
            skid_vld  <= 1'b0;
            skid      <= '0;
        end else begin
            cnt       <= cnt_n;
            frame_err <= err_n;
            if (state != DRAIN) rd_cnt <= '0;
            else if (re)        rd_cnt <= rd_cnt + (LAYER+1)'(1);
            if (re) begin
                out_valid <= 1'b1;
                out_index <= rd_cnt[LAYER-1:0];
                out_last  <= (rd_cnt == (LAYER+1)'(N-1));
            end else if (hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            // park the prefetched word while the consumer stalls
            if (re || hs) begin
                skid_vld <= 1'b0;
            end else if (out_valid && !skid_vld) begin
                skid_vld <= 1'b1;
                skid     <= rdata;
            end
        end
    end

    assign dout              = out_valid ? (skid_vld ? skid : rdata) : '0;
    assign bus.data_out_real = dout[2*DW-1:DW];
    assign bus.data_out_img  = dout[DW-1:0];
    assign bus.out_valid     = out_valid;
    assign bus.out_last      = out_last;
    assign bus.out_index     = out_index;
    assign bus.frame_err     = frame_err;
    assign bus.busy          = (state != IDLE);
endmodule
